// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - shared types and helpers for the C-side gather stage
//
// Purpose : state encoding, counter type, beat/tile derivations and a
//           signed saturate helper shared by gather_c and sat_quant.
// Ports   : none (package).
package accel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WRITE   = 3'd2,
    ST_DONE    = 3'd4
  } state_t;

  typedef logic [15:0] cnt_t;

  // BRAM words needed to hold one packed N-lane row.
  function automatic int beats_of(input int n, input int w, input int bram_w);
    return n * w / bram_w;
  endfunction

  // Column tiles across the C matrix.
  function automatic int tiles_of(input int size_x, input int n);
    return size_x / n;
  endfunction

  // Clamp a signed value into the range of a w-bit two's complement number.
  function automatic logic signed [63:0] sat_s(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/gather_c_if.sv
// rtl/gather_c_if.sv - row handshake between systolic array and gather stage
//
// Purpose : carries one N-lane accumulator row per c_valid & c_ready.
// Signals : c_valid (source), c_ready (sink), c_in[N*ACC_W] (source),
//           lane j at c_in[ACC_W*j +: ACC_W].
interface gather_c_if #(
  parameter int N     = 64,
  parameter int ACC_W = 32
);
  logic               c_valid;
  logic               c_ready;
  logic [N*ACC_W-1:0] c_in;

  modport master (output c_valid, output c_in, input c_ready);
  modport slave  (input c_valid, input c_in, output c_ready);
endinterface

// File: rtl/sat_quant.sv
// rtl/sat_quant.sv - one-lane requantizer: round, arithmetic shift, saturate
//
// Purpose : maps a signed ACC_W accumulator to a signed W-bit element.
// Ports   : i_acc [ACC_W] signed accumulator in
//           o_q   [W]     saturated, rounded, shifted element out
module sat_quant
  import accel_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int W     = 8,
  parameter int SHIFT = 0
) (
  input  logic [ACC_W-1:0] i_acc,
  output logic [W-1:0]     o_q
);

  // Half-LSB rounding constant; zero when no shift is applied.
  localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_W:0] RND = (SHIFT > 0) ? (ACC_W + 1)'(1) << RS : '0;

  logic signed [ACC_W:0] w_t;
  logic signed [ACC_W:0] w_sh;

  // One guard bit keeps the rounding add from overflowing.
  assign w_t  = $signed({i_acc[ACC_W-1], i_acc}) + RND;
  assign w_sh = w_t >>> SHIFT;
  assign o_q  = W'(sat_s(64'(w_sh), W));

endmodule

// File: rtl/gather_c.sv
// rtl/gather_c.sv - requantize accumulator rows and write them into the C BRAM
//
// Purpose : accepts one N-lane row per handshake, requantizes every lane to
//           W bits, packs lane j at bits [W*j +: W] and writes the row as
//           BEATS consecutive BRAM words, row-major per column tile.
// Ports   : clk, rst           clock, synchronous active-high reset
//           start              begin a matrix (IDLE only)
//           c_if (slave)       c_valid / c_ready / c_in row handshake
//           bram_*_c           C BRAM write port (registered)
//           tile_done          pulse after last row of a column tile
//           all_done           pulse after the last word of the matrix
//           busy, debug_state  status
module gather_c
  import accel_pkg::*;
#(
  parameter int W             = 8,
  parameter int N             = 64,
  parameter int ACC_W         = 32,
  parameter int BRAM_W        = 128,
  parameter int BRAM_AW       = 9,
  parameter int DATA_C_SIZE_X = 64,
  parameter int DATA_C_SIZE_Y = 64,
  parameter int SHIFT         = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  gather_c_if.slave          c_if,
  output logic               bram_clk_c,
  output logic               bram_en_c,
  output logic               bram_we_c,
  output logic [BRAM_AW-1:0] bram_addr_c,
  output logic [BRAM_W-1:0]  bram_wrdata_c,
  output logic               tile_done,
  output logic               all_done,
  output logic               busy,
  output logic [2:0]         debug_state
);

  localparam int   BEATS     = beats_of(N, W, BRAM_W);
  localparam int   TILES     = tiles_of(DATA_C_SIZE_X, N);
  localparam int   ROW_WORDS = DATA_C_SIZE_X * W / BRAM_W;
  localparam cnt_t LAST_BEAT = cnt_t'(BEATS - 1);
  localparam cnt_t LAST_ROW  = cnt_t'(DATA_C_SIZE_Y - 1);
  localparam cnt_t LAST_TILE = cnt_t'(TILES - 1);

  state_t             r_state;
  cnt_t               r_row;
  cnt_t               r_tile;
  cnt_t               r_beat;
  logic [N*W-1:0]     r_buf;
  logic               r_en;
  logic               r_we;
  logic [BRAM_AW-1:0] r_addr;
  logic [BRAM_W-1:0]  r_wrdata;
  logic               r_tile_done;
  logic               r_all_done;

  logic [N*W-1:0]     w_q;
  logic               w_last_beat;
  logic               w_row_last;
  logic               w_tile_last;
  logic               w_final;
  logic               w_ready;
  logic               w_hs;
  cnt_t               w_row_nx;
  cnt_t               w_tile_nx;
  logic [BRAM_AW-1:0] w_ld_addr;
  logic [BRAM_W-1:0]  w_next_word;

  function automatic logic [BRAM_AW-1:0] base_addr(input cnt_t row, input cnt_t tile);
    return BRAM_AW'(int'(row) * ROW_WORDS + int'(tile) * BEATS);
  endfunction

  for (genvar j = 0; j < N; j++) begin : g_lane
    sat_quant #(
      .ACC_W (ACC_W),
      .W     (W),
      .SHIFT (SHIFT)
    ) u_quant (
      .i_acc (c_if.c_in[j*ACC_W +: ACC_W]),
      .o_q   (w_q[j*W +: W])
    );
  end

  assign w_last_beat = (r_state == ST_WRITE) && (r_beat == LAST_BEAT);
  assign w_row_last  = (r_row == LAST_ROW);
  assign w_tile_last = (r_tile == LAST_TILE);
  assign w_final     = w_row_last && w_tile_last;

  // Ready depends only on registered state so the source may wait on it.
  // Opening it on the last beat lets rows stream without a bubble.
  assign w_ready = (r_state == ST_COLLECT) || (w_last_beat && !w_final);
  assign w_hs    = c_if.c_valid && w_ready;

  assign w_row_nx  = w_row_last ? '0 : r_row + cnt_t'(1);
  assign w_tile_nx = w_row_last ? (w_tile_last ? '0 : r_tile + cnt_t'(1)) : r_tile;

  // A back-to-back row belongs to the counters as they will be after this beat.
  assign w_ld_addr   = w_last_beat ? base_addr(w_row_nx, w_tile_nx) : base_addr(r_row, r_tile);
  assign w_next_word = r_buf[(int'(r_beat) + 1) * BRAM_W +: BRAM_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_row       <= '0;
      r_tile      <= '0;
      r_beat      <= '0;
      r_buf       <= '0;
      r_en        <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wrdata    <= '0;
      r_tile_done <= 1'b0;
      r_all_done  <= 1'b0;
    end else begin
      r_en        <= 1'b0;
      r_we        <= 1'b0;
      r_tile_done <= 1'b0;
      r_all_done  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_COLLECT;
            r_row   <= '0;
            r_tile  <= '0;
            r_beat  <= '0;
          end
        end
        ST_COLLECT: begin
        end
        ST_WRITE: begin
          if (!w_last_beat) begin
            // Word b is presented while beat_cnt == b.
            r_beat   <= r_beat + cnt_t'(1);
            r_en     <= 1'b1;
            r_we     <= 1'b1;
            r_addr   <= r_addr + BRAM_AW'(1);
            r_wrdata <= w_next_word;
          end else begin
            r_row  <= w_row_nx;
            r_tile <= w_tile_nx;
            if (w_row_last) r_tile_done <= 1'b1;
            if (w_final) begin
              r_state    <= ST_DONE;
              r_all_done <= 1'b1;
            end else begin
              r_state <= ST_COLLECT;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase

      // Handshake loads the row and presents word 0 on the next cycle,
      // overriding the COLLECT fall-back taken on a last beat.
      if (w_hs) begin
        r_state  <= ST_WRITE;
        r_buf    <= w_q;
        r_beat   <= '0;
        r_en     <= 1'b1;
        r_we     <= 1'b1;
        r_addr   <= w_ld_addr;
        r_wrdata <= w_q[BRAM_W-1:0];
      end
    end
  end

  assign c_if.c_ready  = w_ready;
  assign bram_clk_c    = clk;
  assign bram_en_c     = r_en;
  assign bram_we_c     = r_we;
  assign bram_addr_c   = r_addr;
  assign bram_wrdata_c = r_wrdata;
  assign tile_done     = r_tile_done;
  assign all_done      = r_all_done;
  assign busy          = (r_state != ST_IDLE);
  assign debug_state   = r_state;

endmodule

// File: tb/tb_gather_c.sv
// tb/tb_gather_c.sv - scoreboard bench for gather_c (SHIFT=0 and SHIFT=4 instances)
module tb_gather_c;

  localparam int N = 64, ACC_W = 32, W = 8, BRAM_W = 128, AW = 9;
  localparam int ROW_WORDS = 64 * W / BRAM_W;
  localparam int BEATS = N * W / BRAM_W;

  typedef struct packed {
    logic [AW-1:0]     addr;
    logic [BRAM_W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0, start4 = 1'b0;
  logic valid0 = 1'b0, valid4 = 1'b0;
  logic [N*ACC_W-1:0] din = '0;

  logic              bclk0, en0, we0, td0, ad0, busy0;
  logic [AW-1:0]     addr0;
  logic [BRAM_W-1:0] data0;
  logic [2:0]        st0;
  logic              bclk4, en4, we4, td4, ad4, busy4;
  logic [AW-1:0]     addr4;
  logic [BRAM_W-1:0] data4;
  logic [2:0]        st4;

  exp_t q0[$];
  exp_t q4[$];
  int n_checks = 0, n_err = 0;
  int cyc = 0, n_wr0 = 0, n_td0 = 0, n_ad0 = 0, n_td4 = 0, n_ad4 = 0;
  int first_cyc = -1, last_cyc = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  gather_c_if #(.N(N), .ACC_W(ACC_W)) if0 ();
  gather_c_if #(.N(N), .ACC_W(ACC_W)) if4 ();
  assign if0.c_valid = valid0;
  assign if0.c_in    = din;
  assign if4.c_valid = valid4;
  assign if4.c_in    = din;

  gather_c u_dut (
    .clk(clk), .rst(rst), .start(start0), .c_if(if0.slave),
    .bram_clk_c(bclk0), .bram_en_c(en0), .bram_we_c(we0), .bram_addr_c(addr0),
    .bram_wrdata_c(data0), .tile_done(td0), .all_done(ad0), .busy(busy0),
    .debug_state(st0)
  );

  gather_c #(.SHIFT(4), .DATA_C_SIZE_Y(1)) u_dut_s4 (
    .clk(clk), .rst(rst), .start(start4), .c_if(if4.slave),
    .bram_clk_c(bclk4), .bram_en_c(en4), .bram_we_c(we4), .bram_addr_c(addr4),
    .bram_wrdata_c(data4), .tile_done(td4), .all_done(ad4), .busy(busy4),
    .debug_state(st4)
  );

  task automatic check(input string tag, input logic [BRAM_W-1:0] obs, input logic [BRAM_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pack_row(input logic [N*ACC_W-1:0] d, input int sh);
    logic [N*W-1:0] r;
    longint v;
    r = '0;
    for (int j = 0; j < N; j++) begin
      v = longint'($signed(d[j*ACC_W +: ACC_W]));
      if (sh > 0) v = v + (longint'(1) << (sh - 1));
      v = v >>> sh;
      if (v > 127) v = 127;
      if (v < -128) v = -128;
      r[j*W +: W] = v[7:0];
    end
    return r;
  endfunction

  function automatic logic [N*ACC_W-1:0] rand_row();
    logic [N*ACC_W-1:0] d;
    for (int j = 0; j < N; j++) d[j*ACC_W +: ACC_W] = 32'($urandom_range(0, 1023)) - 32'd512;
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one row, waits for ready, queues its expected words; returns just
  // after the handshake edge with valid still high.
  task automatic send_row(input int sel, input logic [N*ACC_W-1:0] d, input int row, input int gap);
    logic [N*W-1:0] p;
    exp_t e;
    int n;
    if (gap > 0) begin
      if (sel == 0) valid0 = 1'b0; else valid4 = 1'b0;
      repeat (gap) tick();
      if (sel == 0) check("stall_state", 128'(st0), 128'(1));
    end
    din = d;
    if (sel == 0) valid0 = 1'b1; else valid4 = 1'b1;
    n = 0;
    while (((sel == 0) ? if0.c_ready : if4.c_ready) !== 1'b1) begin
      tick();
      n++;
      if (n > 50) begin
        check("ready_timeout", 128'(0), 128'(1));
        return;
      end
    end
    p = pack_row(d, (sel == 0) ? 0 : 4);
    for (int b = 0; b < BEATS; b++) begin
      e.addr = AW'(row * ROW_WORDS + b);
      e.data = p[b*BRAM_W +: BRAM_W];
      if (sel == 0) q0.push_back(e); else q4.push_back(e);
    end
    tick();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (we0 === 1'b1) begin
      if (q0.size() == 0) check("wr0_unexpected", 128'(addr0), 128'(9'h1ff));
      else begin
        e = q0.pop_front();
        check("wr0_addr", 128'(addr0), 128'(e.addr));
        check("wr0_data", data0, e.data);
      end
      n_wr0++;
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
    end
    if (td0 === 1'b1) n_td0++;
    if (ad0 === 1'b1) n_ad0++;
  end

  always @(negedge clk) begin
    exp_t e;
    if (we4 === 1'b1) begin
      if (q4.size() == 0) check("wr4_unexpected", 128'(addr4), 128'(9'h1ff));
      else begin
        e = q4.pop_front();
        check("wr4_addr", 128'(addr4), 128'(e.addr));
        check("wr4_data", data4, e.data);
      end
    end
    if (td4 === 1'b1) n_td4++;
    if (ad4 === 1'b1) n_ad4++;
  end

  initial begin
    logic [N*ACC_W-1:0] d;
    int wr_base, i;

    // Reset and idle: c_valid without start must be ignored.
    repeat (3) tick();
    rst = 1'b0;
    valid0 = 1'b1;
    tick();
    tick();
    check("idle_ready", 128'(if0.c_ready), 128'(0));
    check("idle_we", 128'(we0), 128'(0));
    check("idle_en", 128'(en0), 128'(0));
    check("idle_addr", 128'(addr0), 128'(0));
    check("idle_data", data0, 128'(0));
    check("idle_done", 128'({td0, ad0, busy0}), 128'(0));
    check("idle_state", 128'(st0), 128'(0));
    valid0 = 1'b0;

    // Ramp row then a full matrix with c_valid held high.
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check("collect_busy", 128'(busy0), 128'(1));
    first_cyc = -1;
    wr_base = n_wr0;
    for (int j = 0; j < N; j++) d[j*ACC_W +: ACC_W] = 32'(j - 32);
    send_row(0, d, 0, 0);
    check("lat_we", 128'(we0), 128'(1));
    check("lat_addr", 128'(addr0), 128'(0));
    check("ramp_byte0", 128'(data0[7:0]), 128'(8'hE0));
    check("ramp_byte15", 128'(data0[127:120]), 128'(8'hEF));
    for (int r = 1; r < 64; r++) send_row(0, rand_row(), r, 0);
    valid0 = 1'b0;
    i = 0;
    while (ad0 !== 1'b1 && i < 20) begin
      tick();
      i++;
    end
    check("all_done_seen", 128'(ad0), 128'(1));
    tick();
    check("busy_fall", 128'(busy0), 128'(0));
    check("done_state", 128'(st0), 128'(0));
    check("full_writes", 128'(n_wr0 - wr_base), 128'(256));
    check("full_no_gap", 128'(last_cyc - first_cyc), 128'(255));
    check("tile_done_cnt", 128'(n_td0), 128'(1));
    check("all_done_cnt", 128'(n_ad0), 128'(1));

    // Stalled source: 5 idle cycles between rows.
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int r = 0; r < 6; r++) send_row(0, rand_row(), r, 5);

    // Reset in the middle of row 6, at beat 2.
    send_row(0, rand_row(), 6, 0);
    valid0 = 1'b0;
    tick();
    tick();
    check("beat2_addr", 128'(addr0), 128'(6 * ROW_WORDS + 2));
    rst = 1'b1;
    tick();
    check("rst_we", 128'(we0), 128'(0));
    check("rst_state", 128'(st0), 128'(0));
    check("rst_pending", 128'(q0.size()), 128'(1));
    q0.delete();
    rst = 1'b0;
    tick();
    check("rst_no_write", 128'(we0), 128'(0));
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    send_row(0, rand_row(), 0, 0);
    valid0 = 1'b0;
    check("restart_addr", 128'(addr0), 128'(0));
    repeat (6) tick();
    check("q0_drained", 128'(q0.size()), 128'(0));

    // Saturation and rounding at SHIFT=4 (single-row matrix).
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    d = '0;
    d[0*ACC_W +: ACC_W] = 32'd3000;
    d[1*ACC_W +: ACC_W] = -32'sd3000;
    d[2*ACC_W +: ACC_W] = 32'd23;
    d[3*ACC_W +: ACC_W] = 32'd24;
    d[4*ACC_W +: ACC_W] = -32'sd24;
    send_row(1, d, 0, 0);
    valid4 = 1'b0;
    check("sat_lanes", 128'(data4[39:0]), 128'(40'hFF_02_01_80_7F));
    repeat (8) tick();
    check("s4_tile_done", 128'(n_td4), 128'(1));
    check("s4_all_done", 128'(n_ad4), 128'(1));
    check("s4_idle", 128'(st4), 128'(0));
    check("q4_drained", 128'(q4.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gather_c.md
Name: gather_c

Overview:
- Output-side stage of the matrix engine. Accepts one N-lane row of ACC_W-bit accumulator results per handshake from the systolic array.
- Requantizes each lane to W bits (round, arithmetic shift, saturate) and packs the row into BRAM_W-bit words.
- Writes the words row-major into the C result BRAM.
- Lane/bit packing mirrors the A-side scatter: lane j occupies bits [W*j+W-1 : W*j].

Parameters:
W, 8, output element width (signed)
N, 64, lanes per row
ACC_W, 32, accumulator width per lane (signed)
BRAM_W, 128, BRAM data width; N*W must be a multiple of BRAM_W
BRAM_AW, 9, BRAM address width
DATA_C_SIZE_X, 64, C matrix columns; multiple of N
DATA_C_SIZE_Y, 64, C matrix rows
SHIFT, 0, requantization right shift, 0..ACC_W-2

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
start  in  1  begin a new matrix; honoured only in IDLE
c_valid  in  1  row valid from array
c_ready  out  1  row accepted when c_valid & c_ready
c_in  in  N*ACC_W  row results, lane j = c_in[j]
bram_clk_c  out  1  = clk
bram_en_c  out  1  BRAM enable
bram_we_c  out  1  BRAM write strobe
bram_addr_c  out  BRAM_AW  word address
bram_wrdata_c  out  BRAM_W  write data
tile_done  out  1  1-cycle pulse after last row of a column tile is written
all_done  out  1  1-cycle pulse after last word of matrix is written
busy  out  1  state != IDLE
debug_state  out  3  current state encoding

Behaviour:
- Constants: BEATS = N*W/BRAM_W (default 4); TILES = DATA_C_SIZE_X/N (default 1).
- States: IDLE=0, COLLECT=1, WRITE=2, DONE=4.
- Reset:
  - state IDLE; row_cnt, tile_cnt, beat_cnt cleared.
  - All outputs 0: c_ready, bram_en_c, bram_we_c, bram_addr_c, bram_wrdata_c, tile_done, all_done, busy.
  - rst mid-operation abandons the row in flight; no further writes.
- IDLE:
  - start -> COLLECT, with counters cleared.
  - c_valid is ignored (c_ready=0).
- COLLECT:
  - c_ready=1.
  - On handshake: each lane requantized into the row buffer; beat_cnt=0; -> WRITE.
- WRITE (one word per cycle, registered outputs):
  - bram_en_c = bram_we_c = 1.
  - bram_wrdata_c = buffer[BRAM_W*beat+BRAM_W-1 : BRAM_W*beat].
  - bram_addr_c = (row_cnt*DATA_C_SIZE_X + tile_cnt*N)*W/BRAM_W + beat_cnt, truncated to BRAM_AW.
  - beat_cnt increments each cycle.
- Last beat (beat_cnt == BEATS-1):
  - If row_cnt == DATA_C_SIZE_Y-1: row_cnt=0 and tile_done pulses next cycle.
    - If tile_cnt == TILES-1: -> DONE.
    - Otherwise tile_cnt++ and -> COLLECT.
  - Otherwise row_cnt++.
  - Back-to-back: c_ready=1 during the last beat unless this is the final row of the final tile. A handshake in that cycle loads the buffer and remains in WRITE with beat_cnt=0 (no bubble). Without a handshake -> COLLECT.
- DONE: all_done=1 for one cycle; -> IDLE.
- Throughput: one row per BEATS cycles sustained. Latency from handshake to first write = 1 cycle.
- Requantization, per lane:
  - t = c_in[j] + (SHIFT>0 ? 2^(SHIFT-1) : 0), computed in ACC_W+1 bits signed.
  - t >>>= SHIFT.
  - Saturate to [-2^(W-1), 2^(W-1)-1].
- start outside IDLE is ignored. c_in is sampled only on handshake. c_ready is combinational from state/counters only, never from c_valid.

Decomposition:
- Shared package accel_pkg: state enum (IDLE/COLLECT/WRITE/DONE encodings), BEATS and TILES derivation functions, signed saturate function.
- Sub-module sat_quant (one lane: round, shift, saturate), generated N times.

Test Plan:
- Reset/idle: hold rst 3 cycles, then c_valid=1 with no start -> c_ready=0, bram_we_c=0, all outputs 0, debug_state=0.
- Ramp row, SHIFT=0: lane j = j-32 -> addr 0..3 written in 4 consecutive cycles. Word 0 byte0=0xE0, byte15=0xEF.
- Saturation, SHIFT=4: lanes 3000, -3000, 23, 24, -24 -> 127, -128, 1, 2, -1. Checks round-half-up: 24 -> 1.5 -> 2; -24 -> -1.5 -> -1.
- Full matrix with c_valid held high: 64 rows -> 256 writes at addr 0..255, no idle cycles between rows. tile_done and all_done each pulse once; busy falls after DONE.
- Stalled source: c_valid low 5 cycles between rows -> state waits in COLLECT, no writes, addressing continues at row_cnt*4.
- Reset mid-row: assert rst at beat 2 -> next cycle bram_we_c=0, state IDLE. A fresh start rewrites from addr 0.
